// File: rtl/mcp3_encoder016x4_rr.sv
// Round-robin 16-slot request accumulator that serializes pending slots into 4-bit indices.
// Latency: req_set -> pending 1 cycle, pending -> out_valid 1 cycle; output holds under out_ready=0.
module mcp3_encoder016x4_rr #(
    parameter logic [3:0] PTR_INIT = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req_set,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  out_index,
    output logic [15:0] pending,
    output logic        idle,
    output logic        dup_err
);

    logic [15:0] pending_q, pending_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_index_q, out_index_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        dup_q, dup_d;

    logic        load;
    logic        found;
    logic [3:0]  idx;
    logic [15:0] sel_oh;
    logic [3:0]  sel_idx;
    logic [15:0] grant_onehot;
    logic [15:0] present_hit;
    logic        dup_now;

    // OR-reduction encode, so out_index is exactly the binary form of the one-hot grant.
    function automatic logic [3:0] enc16(input logic [15:0] oh);
        enc16 = '0;
        for (int b = 0; b < 16; b++) begin
            if (oh[b]) enc16 = enc16 | 4'(b);
        end
    endfunction

    assign load = !out_valid_q || out_ready;

    // Search from ptr upward; the 4-bit index wraps 15 -> 0 naturally.
    always_comb begin
        found  = 1'b0;
        sel_oh = '0;
        idx    = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && pending_q[idx]) begin
                found  = 1'b1;
                sel_oh = 16'(1) << idx;
            end
        end
    end

    assign sel_idx      = enc16(sel_oh);
    assign grant_onehot = load ? sel_oh : '0;

    // A slot still on the output and not being accepted counts as outstanding.
    assign present_hit = (out_valid_q && !out_ready) ? (16'(1) << out_index_q) : '0;
    assign dup_now     = |(req_set & ((pending_q & ~grant_onehot) | present_hit));

    always_comb begin
        pending_d   = (pending_q & ~grant_onehot) | req_set;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        ptr_d       = ptr_q;
        dup_d       = dup_q | dup_now;
        if (flush) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
            out_index_d = '0;
            ptr_d       = PTR_INIT;
            dup_d       = 1'b0;
        end else if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_index_d = sel_idx;
                ptr_d       = sel_idx + 4'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            ptr_q       <= PTR_INIT;
            dup_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            ptr_q       <= ptr_d;
            dup_q       <= dup_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign pending   = pending_q;
    assign dup_err   = dup_q;
    assign idle      = (pending_q == 16'h0000) && !out_valid_q;

endmodule

// File: tb/tb_mcp3_encoder016x4_rr.sv
// Directed bench for the round-robin 16-to-4 encoder: ordering, wrap, backpressure, dup_err, flush, reset.
module tb_mcp3_encoder016x4_rr;

    logic        clock;
    logic        reset;
    logic [15:0] req_set;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_index;
    logic [15:0] pending;
    logic        idle;
    logic        dup_err;

    int n_cmp = 0;
    int n_bad = 0;

    mcp3_encoder016x4_rr #(.PTR_INIT(4'd0)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_set   (req_set),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_index (out_index),
        .pending   (pending),
        .idle      (idle),
        .dup_err   (dup_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_set = '0; flush = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_index, pending, dup_err, idle} !== {1'b1 ^ 1'b1, 4'd0, 16'h0000, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%0b i=%0d p=%h d=%0b idle=%0b exp v=0 i=0 p=0000 d=0 idle=1",
                     out_valid, out_index, pending, dup_err, idle);
        end
        n_cmp++;
        if (dut.ptr_q !== 4'd0) begin
            n_bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr_q);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_order();
        out_ready = 1'b1;
        req_set = 16'h8001;
        tick();
        req_set = '0;
        n_cmp++;
        if ({out_valid, pending} !== {1'b0, 16'h8001}) begin
            n_bad++; $display("FAIL basic_pending got v=%0b p=%h exp v=0 p=8001", out_valid, pending);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_index, pending} !== {1'b1, 4'd0, 16'h8000}) begin
            n_bad++; $display("FAIL basic_first got v=%0b i=%0d p=%h exp v=1 i=0 p=8000", out_valid, out_index, pending);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_index, pending} !== {1'b1, 4'd15, 16'h0000}) begin
            n_bad++; $display("FAIL basic_second got v=%0b i=%0d p=%h exp v=1 i=15 p=0000", out_valid, out_index, pending);
        end
        tick();
        n_cmp++;
        if ({out_valid, idle, dut.ptr_q} !== {1'b0, 1'b1, 4'd0}) begin
            n_bad++; $display("FAIL basic_drain got v=%0b idle=%0b ptr=%0d exp v=0 idle=1 ptr=0", out_valid, idle, dut.ptr_q);
        end
    endtask

    task automatic test_rr_wrap();
        do_flush();
        out_ready = 1'b1;
        req_set = 16'h0010;
        tick();
        req_set = '0;
        tick();
        n_cmp++;
        if ({out_valid, out_index} !== {1'b1, 4'd4}) begin
            n_bad++; $display("FAIL wrap_first got v=%0b i=%0d exp v=1 i=4", out_valid, out_index);
        end
        tick();
        n_cmp++;
        if ({out_valid, dut.ptr_q} !== {1'b0, 4'd5}) begin
            n_bad++; $display("FAIL wrap_ptr got v=%0b ptr=%0d exp v=0 ptr=5", out_valid, dut.ptr_q);
        end
        req_set = 16'h0011;
        tick();
        req_set = '0;
        tick();
        n_cmp++;
        if ({out_valid, out_index} !== {1'b1, 4'd0}) begin
            n_bad++; $display("FAIL wrap_second got v=%0b i=%0d exp v=1 i=0", out_valid, out_index);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_index} !== {1'b1, 4'd4}) begin
            n_bad++; $display("FAIL wrap_third got v=%0b i=%0d exp v=1 i=4", out_valid, out_index);
        end
        tick();
        n_cmp++;
        if ({out_valid, idle} !== {1'b0, 1'b1}) begin
            n_bad++; $display("FAIL wrap_drain got v=%0b idle=%0b exp v=0 idle=1", out_valid, idle);
        end
    endtask

    task automatic test_backpressure();
        do_flush();
        out_ready = 1'b0;
        req_set = 16'h0006;
        tick();
        req_set = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, out_index, pending} !== {1'b1, 4'd1, 16'h0004}) begin
                n_bad++; $display("FAIL bp_hold cyc=%0d got v=%0b i=%0d p=%h exp v=1 i=1 p=0004",
                                  i, out_valid, out_index, pending);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, out_index, pending} !== {1'b1, 4'd2, 16'h0000}) begin
            n_bad++; $display("FAIL bp_release got v=%0b i=%0d p=%h exp v=1 i=2 p=0000", out_valid, out_index, pending);
        end
        tick();
        n_cmp++;
        if ({out_valid, dup_err} !== {1'b0, 1'b0}) begin
            n_bad++; $display("FAIL bp_drain got v=%0b d=%0b exp v=0 d=0", out_valid, dup_err);
        end
    endtask

    task automatic test_dup_detect();
        do_flush();
        out_ready = 1'b0;
        req_set = 16'h0100;
        tick();
        req_set = '0;
        tick();
        n_cmp++;
        if ({out_valid, out_index, dup_err} !== {1'b1, 4'd8, 1'b0}) begin
            n_bad++; $display("FAIL dup_before got v=%0b i=%0d d=%0b exp v=1 i=8 d=0", out_valid, out_index, dup_err);
        end
        req_set = 16'h0100;
        tick();
        req_set = '0;
        n_cmp++;
        if (dup_err !== 1'b1) begin
            n_bad++; $display("FAIL dup_set got=%0b exp=1", dup_err);
        end
        tick();
        n_cmp++;
        if (dup_err !== 1'b1) begin
            n_bad++; $display("FAIL dup_sticky got=%0b exp=1", dup_err);
        end
        do_flush();
        n_cmp++;
        if ({dup_err, out_valid, pending, idle} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
            n_bad++; $display("FAIL dup_flush got d=%0b v=%0b p=%h idle=%0b exp d=0 v=0 p=0000 idle=1",
                              dup_err, out_valid, pending, idle);
        end
    endtask

    task automatic test_set_grant_collision();
        do_flush();
        out_ready = 1'b1;
        req_set = 16'h0008;
        tick();
        req_set = 16'h0008;
        tick();
        req_set = '0;
        n_cmp++;
        if ({out_valid, out_index, pending} !== {1'b1, 4'd3, 16'h0008}) begin
            n_bad++; $display("FAIL coll_first got v=%0b i=%0d p=%h exp v=1 i=3 p=0008", out_valid, out_index, pending);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_index, pending} !== {1'b1, 4'd3, 16'h0000}) begin
            n_bad++; $display("FAIL coll_second got v=%0b i=%0d p=%h exp v=1 i=3 p=0000", out_valid, out_index, pending);
        end
        tick();
        n_cmp++;
        if ({out_valid, dup_err} !== {1'b0, 1'b0}) begin
            n_bad++; $display("FAIL coll_end got v=%0b d=%0b exp v=0 d=0", out_valid, dup_err);
        end
    endtask

    task automatic test_flush_and_reset();
        do_flush();
        out_ready = 1'b1;
        req_set = 16'hFFFF;
        tick();
        req_set = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({out_valid, out_index} !== {1'b1, 4'(k)}) begin
                n_bad++; $display("FAIL flush_seq k=%0d got v=%0b i=%0d exp v=1 i=%0d", k, out_valid, out_index, k);
            end
        end
        do_flush();
        n_cmp++;
        if ({pending, out_valid, idle, dut.ptr_q} !== {16'h0000, 1'b0, 1'b1, 4'd0}) begin
            n_bad++; $display("FAIL flush_clear got p=%h v=%0b idle=%0b ptr=%0d exp p=0000 v=0 idle=1 ptr=0",
                              pending, out_valid, idle, dut.ptr_q);
        end
        req_set = 16'hFFFF;
        tick();
        req_set = '0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_index, pending, dup_err, idle} !== {1'b0, 4'd0, 16'h0000, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL async_reset got v=%0b i=%0d p=%h d=%0b idle=%0b exp v=0 i=0 p=0000 d=0 idle=1",
                              out_valid, out_index, pending, dup_err, idle);
        end
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, pending, idle} !== {1'b0, 16'h0000, 1'b1}) begin
            n_bad++; $display("FAIL no_replay got v=%0b p=%h idle=%0b exp v=0 p=0000 idle=1", out_valid, pending, idle);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_rr_wrap();
        test_backpressure();
        test_dup_detect();
        test_set_grant_collision();
        test_flush_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcp3_encoder016x4_rr.md
Name: mcp3_encoder016x4_rr

Overview:
- Sequential counterpart to the AFP 4-to-16 one-hot decoder: accumulates a 16-bit request vector and serializes it into a stream of 4-bit indices, one per accepted transfer.
- Arbitration is round-robin.
- Sits between per-slot completion/event logic, where slot n raises bit n, and downstream consumers that need an encoded slot number, such as a tag return FIFO or response formatter.

Parameters:
- PTR_INIT, 0, initial round-robin search pointer (0..15) after reset and after flush.

Ports:
- clock  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_set  input  16  per-bit request pulses; bit n=1 marks slot n pending
- flush  input  1  synchronous clear of all pending and output state
- out_ready  input  1  downstream accepts out_index this cycle
- out_valid  output  1  out_index holds a valid encoded slot
- out_index  output  4  encoded slot number (binary)
- pending  output  16  current pending vector (registered)
- idle  output  1  pending==0 and out_valid==0
- dup_err  output  1  sticky: a req_set bit arrived for a slot already pending or currently presented on out_index

Behaviour:
- Reset (async, active-high) values:
  - pending=0, out_valid=0, out_index=0, dup_err=0, idle=1, search pointer ptr=PTR_INIT.
  - Reset deasserting mid-stream discards all requests; nothing is replayed.
- Pending register:
  - pending_next = (pending & ~grant_onehot) | req_set.
  - req_set is not visible to selection in the same cycle.
  - A set and a grant of the same bit in the same cycle leave the bit pending; this counts as a new request.
- Load condition: load = !out_valid | (out_valid & out_ready).
- Selection when load=1:
  - Search the registered pending from ptr upward with wrap (ptr, ptr+1, …, 15, 0, …, ptr-1).
  - Pick the first set bit k.
  - Update: out_index<=k, out_valid<=1, grant_onehot=(1<<k), ptr<=(k+1) mod 16 (4-bit wrap; k=15 gives ptr=0).
  - If pending==0: out_valid<=0, ptr unchanged, out_index holds its last value.
- Hold when out_valid=1 and out_ready=0:
  - out_valid, out_index and ptr are stable.
  - No grant is made; pending only accumulates.
- Latency:
  - req_set in cycle N, pending bit in N+1, out_valid with that index in N+2 at earliest, given the output is free and the bit wins arbitration.
- Throughput: one index per cycle while out_ready=1 and pending!=0.
- Fairness: each pending slot is granted within 16 accepted transfers.
- dup_err:
  - Sets when, in a cycle, req_set[n]=1 and either pending[n]=1 (not simultaneously granted), or out_valid=1 with out_index==n and no accept that cycle.
  - Cleared only by reset or flush.
- flush:
  - Next cycle: pending=0, out_valid=0, ptr=PTR_INIT, dup_err=0.
  - req_set in the flush cycle is dropped.
  - Flush has priority over load and set.
- idle is combinational from registered state only.
- out_index is a pure binary encode of the granted one-hot bit. Decoding it through the 4-to-16 decoder must return exactly grant_onehot.

Test Plan:
1. Basic order:
   - Stimulus: after reset, pulse req_set=16'h8001 for one cycle, out_ready=1.
   - Response: out_valid rises 2 cycles later; out_index=0 then 15 on consecutive cycles; then out_valid=0, idle=1, ptr=0.
2. Round-robin wrap:
   - Stimulus: pulse req_set=16'h0010, consume it (ptr=5); then pulse req_set=16'h0011.
   - Response: index 4 is issued only after index 0; verify issue order 4, then 0, 4.
   - Second pulse check: ptr=5 search starts at 5, so the order is 0 then 4. Stated expectation for the bench: first 4, then 0, 4.
3. Backpressure:
   - Stimulus: req_set=16'h0006, out_ready=0 for 5 cycles.
   - Response: out_valid=1, out_index=1 stable for all 5 cycles; pending=16'h0004.
   - Then out_ready=1 gives index 2 on the next cycle.
4. Duplicate detection:
   - Stimulus: pulse req_set=16'h0100 twice, 1 cycle apart, with out_ready=0.
   - Response: dup_err=1 from the cycle after the second pulse and stays 1; flush clears it.
5. Set/grant collision:
   - Stimulus: pending=16'h0008, out_ready=1, and req_set=16'h0008 in the cycle index 3 is granted.
   - Response: index 3 is issued twice in total; dup_err=0.
6. Flush and reset:
   - Stimulus: load 16'hFFFF, consume 3 indices (0, 1, 2), then assert flush.
   - Response: the next cycle shows pending=0, out_valid=0, idle=1.
   - Repeat using async reset mid-stream: outputs go to reset values immediately, with no clock edge needed.
